// File: rtl/boot_controller.sv
// Boot sequencer: streams a program image into imem, runs the core, then parks it in reset.
// Write strobe 1 cycle after each word's 4th byte; rx_ready only in HEADER/WORDS, up to 1 byte/cycle.
module boot_controller #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int MAX_CYCLES    = 1000000,
  parameter int DRAIN_CYCLES  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [31:0] pc,
  output logic [31:0] imem_write_address,
  output logic [31:0] imem_write_value,
  output logic        imem_write_enable,
  output logic        processor_reset,
  input  logic        load_request,
  output logic        done,
  output logic        timeout,
  output logic        error,
  output logic [31:0] cycle_count
);

  typedef enum logic [2:0] {
    S_HEADER, S_WORDS, S_LAST, S_RUN, S_DRAIN, S_DONE
  } state_t;

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDRESS_WIDTH;
  localparam logic [31:0] MAX_CNT   = 32'(MAX_CYCLES);
  localparam logic [31:0] DRAIN_END = 32'(DRAIN_CYCLES - 1);

  state_t                   state, next_state;
  logic                     hdr_phase;
  logic [7:0]               hdr_hi;
  logic [15:0]              word_count;
  logic [ADDRESS_WIDTH-1:0] index;
  logic [1:0]               byte_idx;
  logic [23:0]              partial;
  logic [31:0]              drain_cnt;

  logic        accept;
  logic [15:0] header_word;
  logic        header_ok;
  logic        last_word;
  logic        halt;
  logic        at_max;
  logic        stop;
  logic        drain_last;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_HEADER;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_HEADER: if (accept && hdr_phase && header_ok) next_state = S_WORDS;
      S_WORDS:  if (accept && byte_idx == 2'd3 && last_word) next_state = S_LAST;
      S_LAST:   next_state = S_RUN;
      S_RUN:    if (stop) next_state = S_DRAIN;
      S_DRAIN:  if (drain_last) next_state = S_DONE;
      S_DONE:   if (load_request) next_state = S_HEADER;
      default:  next_state = S_HEADER;
    endcase
  end

  // Output / decode logic
  always_comb begin
    rx_ready    = !reset && (state == S_HEADER || state == S_WORDS);
    accept      = rx_valid && rx_ready;
    header_word = {hdr_hi, rx_data};
    header_ok   = (header_word != 16'd0) && (32'(header_word) <= MAX_WORDS);
    last_word   = 32'(index) == (32'(word_count) - 32'd1);
    halt        = pc == (32'(word_count) << 2);
    at_max      = cycle_count == MAX_CNT;
    stop        = halt || at_max;
    drain_last  = drain_cnt == DRAIN_END;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hdr_phase          <= 1'b0;
      hdr_hi             <= 8'd0;
      word_count         <= 16'd0;
      index              <= '0;
      byte_idx           <= 2'd0;
      partial            <= 24'd0;
      drain_cnt          <= 32'd0;
      imem_write_address <= 32'd0;
      imem_write_value   <= 32'd0;
      imem_write_enable  <= 1'b0;
      processor_reset    <= 1'b1;
      done               <= 1'b0;
      timeout            <= 1'b0;
      error              <= 1'b0;
      cycle_count        <= 32'd0;
    end else begin
      imem_write_enable <= 1'b0;
      processor_reset   <= !(next_state == S_RUN || next_state == S_DRAIN);
      done              <= next_state == S_DONE;
      case (state)
        S_HEADER: begin
          if (accept) begin
            if (!hdr_phase) begin
              hdr_hi    <= rx_data;
              hdr_phase <= 1'b1;
            end else begin
              hdr_phase <= 1'b0;
              if (header_ok) begin
                error      <= 1'b0;
                word_count <= header_word;
                index      <= '0;
                byte_idx   <= 2'd0;
              end else begin
                error <= 1'b1;
              end
            end
          end
        end
        S_WORDS: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem_write_enable  <= 1'b1;
              imem_write_address <= 32'(index) << 2;
              imem_write_value   <= {partial, rx_data};
              index              <= index + ADDRESS_WIDTH'(1);
            end else begin
              partial <= {partial[15:0], rx_data};
            end
          end
        end
        S_RUN: begin
          drain_cnt <= 32'd0;
          // Halt has priority, so a simultaneous budget hit is not a timeout.
          if (stop) timeout     <= !halt;
          else      cycle_count <= cycle_count + 32'd1;
        end
        S_DRAIN: drain_cnt <= drain_cnt + 32'd1;
        S_DONE: begin
          if (load_request) begin
            timeout     <= 1'b0;
            error       <= 1'b0;
            cycle_count <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_controller.sv
// Bench for boot_controller: scenario table, header table and randomized images vs a reference model.
module tb_boot_controller;

  localparam int AW    = 8;
  localparam int MAXC  = 10;
  localparam int DRAIN = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] pc = 32'd0;
  logic [31:0] imem_write_address;
  logic [31:0] imem_write_value;
  logic        imem_write_enable;
  logic        processor_reset;
  logic        load_request = 1'b0;
  logic        done;
  logic        timeout;
  logic        error;
  logic [31:0] cycle_count;

  boot_controller #(.ADDRESS_WIDTH(AW), .MAX_CYCLES(MAXC), .DRAIN_CYCLES(DRAIN)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .pc(pc), .imem_write_address(imem_write_address), .imem_write_value(imem_write_value),
    .imem_write_enable(imem_write_enable), .processor_reset(processor_reset),
    .load_request(load_request), .done(done), .timeout(timeout), .error(error),
    .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] val;
    int          cyc;
  } wr_t;

  typedef struct {
    int n;
    int gap;
    int halt;
    bit fixed;
    int exp_cc;
    bit exp_to;
  } scen_t;

  typedef struct {
    logic [15:0] hdr;
    logic        exp_err;
  } hdr_vec_t;

  int  n_chk = 0;
  int  n_fail = 0;
  int  cyc = 0;
  wr_t wq[$];
  int  hq[$];
  logic [31:0] fw [3] = '{32'h20080005, 32'h21090001, 32'h00000000};

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (imem_write_enable) wq.push_back('{imem_write_address, imem_write_value, cyc});
    if (rx_valid && rx_ready) hq.push_back(cyc);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int gap_len(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 2));
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    for (int i = 0; i < gap; i++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(posedge clock); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (rx_ready) ok = 1;
      @(posedge clock); #1;
      if (ok) break;
    end
    rx_valid = 1'b0;
    if (!ok) chk("byte_accept", 32'd0, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag, input logic exp_rdy);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'(exp_rdy));
    chk({tag, "_prst"}, 32'(processor_reset), 32'd1);
    chk({tag, "_we"}, 32'(imem_write_enable), 32'd0);
    chk({tag, "_addr"}, imem_write_address, 32'd0);
    chk({tag, "_val"}, imem_write_value, 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_cc"}, cycle_count, 32'd0);
  endtask

  task automatic do_reset(input bit check);
    reset = 1'b1;
    rx_valid = 1'b0;
    load_request = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    if (check) begin @(negedge clock); check_idle_outputs("rst", 1'b0); end
    @(posedge clock); #1;
    reset = 1'b0;
    if (check) begin @(negedge clock); check_idle_outputs("post_rst", 1'b1); end
    @(posedge clock); #1;
  endtask

  // Load an image, run the core with a pc that hits 4N at RUN cycle 'halt', check writes and outcome.
  task automatic run_scenario(input int n, input int gap, input int halt, input bit fixed,
                              input int exp_cc, input bit exp_to);
    logic [31:0] img[$];
    logic [31:0] w;
    logic [15:0] nh;
    int fall = -1;
    int done_cyc = -1;
    int k;
    bit got = 0;
    for (int i = 0; i < n; i++) img.push_back((fixed && i < 3) ? fw[i] : $urandom);
    wq = {};
    hq = {};
    nh = 16'(n);
    send_byte(nh[15:8], gap_len(gap));
    send_byte(nh[7:0], gap_len(gap));
    for (int i = 0; i < n; i++) begin
      w = img[i];
      for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8], gap_len(gap));
    end
    rx_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      rx_data = 8'($urandom);
      if (fall < 0 && !processor_reset) fall = cyc;
      if (fall >= 0) begin
        k = cyc - fall;
        pc = (k == halt) ? 32'(4 * n) : 32'(4 * (k % n));
        load_request = (k == 1);
      end
      @(negedge clock);
      if (done) begin done_cyc = cyc; got = 1; break; end
      @(posedge clock); #1;
    end
    rx_valid = 1'b0;
    load_request = 1'b0;
    pc = 32'd0;
    chk("done_rise", 32'(got), 32'd1);
    chk("strobe_count", 32'(wq.size()), 32'(n));
    for (int i = 0; i < n && i < wq.size(); i++) begin
      chk("wr_addr", wq[i].addr, 32'(4 * i));
      chk("wr_val", wq[i].val, img[i]);
      if (hq.size() > 4 * i + 5) chk("wr_latency", 32'(wq[i].cyc), 32'(hq[4 * i + 5] + 1));
    end
    if (wq.size() > 0) chk("prst_fall", 32'(fall), 32'(wq[wq.size() - 1].cyc + 1));
    chk("done_latency", 32'(done_cyc - fall), 32'(exp_cc + DRAIN + 1));
    chk("cycle_count", cycle_count, 32'(exp_cc));
    chk("timeout", 32'(timeout), 32'(exp_to));
    chk("error_run", 32'(error), 32'd0);
    chk("prst_done", 32'(processor_reset), 32'd1);
    chk("rx_ready_done", 32'(rx_ready), 32'd0);
    chk("bytes_consumed", 32'(hq.size()), 32'(2 + 4 * n));
    @(posedge clock); #1;
    chk("done_held", 32'(done), 32'd1);
    load_request = 1'b1;
    @(posedge clock); #1;
    load_request = 1'b0;
    @(negedge clock);
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_cc", cycle_count, 32'd0);
    chk("reload_timeout", 32'(timeout), 32'd0);
    chk("reload_rx_ready", 32'(rx_ready), 32'd1);
    chk("reload_prst", 32'(processor_reset), 32'd1);
    @(posedge clock); #1;
  endtask

  initial begin
    scen_t    stab[7];
    hdr_vec_t htab[4];
    int rn, rh, rg, rcc;
    bit rto;
    logic [15:0] hv;

    stab[0] = '{3, 0, 7, 1'b1, 7, 1'b0};
    stab[1] = '{3, 1, 7, 1'b1, 7, 1'b0};
    stab[2] = '{1, 2, 1000, 1'b0, 10, 1'b1};
    stab[3] = '{2, 0, 10, 1'b0, 10, 1'b0};
    stab[4] = '{2, 1, 0, 1'b0, 0, 1'b0};
    stab[5] = '{256, 0, 3, 1'b0, 3, 1'b0};
    stab[6] = '{4, 2, 11, 1'b0, 10, 1'b1};

    htab[0] = '{16'h0000, 1'b1};
    htab[1] = '{16'h0101, 1'b1};
    htab[2] = '{16'hFFFF, 1'b1};
    htab[3] = '{16'h0003, 1'b0};

    do_reset(1'b1);

    wq = {};
    for (int i = 0; i < 4; i++) begin
      hv = htab[i].hdr;
      send_byte(hv[15:8], 0);
      send_byte(hv[7:0], 0);
      @(negedge clock);
      chk("hdr_error", 32'(error), 32'(htab[i].exp_err));
      chk("hdr_rx_ready", 32'(rx_ready), 32'd1);
      chk("hdr_no_strobe", 32'(wq.size()), 32'd0);
      @(posedge clock); #1;
    end
    do_reset(1'b0);

    for (int i = 0; i < 7; i++)
      run_scenario(stab[i].n, stab[i].gap, stab[i].halt, stab[i].fixed, stab[i].exp_cc, stab[i].exp_to);

    for (int i = 0; i < 8; i++) begin
      rn  = int'($urandom_range(1, 24));
      rg  = int'($urandom_range(0, 2));
      rh  = int'($urandom_range(0, 14));
      rcc = (rh < MAXC) ? rh : MAXC;
      rto = rh > MAXC;
      run_scenario(rn, rg, rh, 1'b0, rcc, rto);
    end

    // Reset in the middle of word 1 must restart from a fresh header at index 0.
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int b = 0; b < 6; b++) send_byte(8'($urandom), 0);
    do_reset(1'b1);
    run_scenario(2, 0, 5, 1'b0, 5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/boot_controller.md
# boot_controller

Sequences the pipelined processor from power-up. It holds the core in reset and receives a program image over a byte-wide valid/ready stream. It writes the image into instruction memory word by word, then releases the core. It watches the PC for end-of-program or a cycle budget, lets the pipeline drain, and parks the core in reset with a completion status and cycle count.

## Interface
- ADDRESS_WIDTH, 8: instruction-memory word-index width; max program is 2^ADDRESS_WIDTH words.
- MAX_CYCLES, 1000000: run-cycle budget before a forced stop.
- DRAIN_CYCLES, 4: cycles the core keeps running after stop detection, so in-flight writebacks complete.

- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- rx_data  in  8  image byte.
- rx_valid  in  1  rx_data holds a byte.
- rx_ready  out  1  controller accepts a byte this cycle.
- pc  in  32  processor PC.
- imem_write_address  out  32  byte address (4 × word index).
- imem_write_value  out  32  assembled instruction word.
- imem_write_enable  out  1  one-cycle write strobe.
- processor_reset  out  1  drives the core's reset.
- load_request  in  1  start a new load; honoured in DONE only.
- done  out  1  program finished, core parked.
- timeout  out  1  stop was caused by MAX_CYCLES.
- error  out  1  the last header was rejected.
- cycle_count  out  32  RUN cycles elapsed.

## Operation
- A byte is accepted when rx_valid && rx_ready.
- rx_ready = !reset && state ∈ {HEADER, WORDS}.
- HEADER: accept 2 bytes, high byte first, forming the 16-bit word count N.
  - N == 0 or N > 2^ADDRESS_WIDTH: set error, discard the header, stay in HEADER.
  - Otherwise: clear error, clear the word index, go to WORDS.
- WORDS: accept bytes big-endian, first byte → [31:24].
  - On the 4th byte, the next cycle pulses imem_write_enable for 1 cycle, with address = 4 × index and the assembled value.
  - Then the index increments.
  - After the pulse for word N−1, go to RUN.
- RUN: processor_reset = 0.
  - Stop conditions, checked every cycle:
    - halt: pc == 4N, compared as 32-bit values.
    - timeout: cycle_count == MAX_CYCLES.
  - If neither holds, cycle_count increments by 1.
  - On a stop, cycle_count freezes, the timeout flag is latched, and the state goes to DRAIN.
  - Halt and timeout in the same cycle: halt wins, timeout = 0.
- DRAIN: processor_reset stays 0 for exactly DRAIN_CYCLES cycles, then go to DONE.
- DONE: processor_reset = 1, done = 1; cycle_count and timeout are held.
  - load_request → HEADER. Clears done, timeout, error and cycle_count; processor_reset stays 1.
- load_request is ignored in all other states.
- rx_data is ignored whenever rx_ready = 0. Bytes arriving in RUN, DRAIN or DONE are not consumed.
- Reset (any state, including mid-word or mid-RUN): state HEADER, partial header and word discarded, index 0.

## Timing
- Reset values, in the reset cycle and the cycle after:
  - processor_reset = 1
  - imem_write_enable = 0, imem_write_address = 0, imem_write_value = 0
  - done = 0, timeout = 0, error = 0, cycle_count = 0
  - rx_ready = 0 during reset, 1 in the first cycle after it.
- All outputs except rx_ready are registered.
- Byte-to-write latency: the write strobe appears 1 cycle after the 4th handshake.
- A new byte may be accepted in the strobe cycle; full throughput is 1 byte/cycle.
- processor_reset falls in the cycle after the last write strobe.
  - That is RUN cycle 0: cycle_count = 0, core PC = 0.
- Stop detected in cycle t: DRAIN occupies t+1 … t+DRAIN_CYCLES; done and processor_reset rise at t+DRAIN_CYCLES+1.
- error updates in the cycle after the 2nd header byte.

## Test plan
- N = 3, words 0x20080005, 0x21090001, 0x00000000 at one byte/cycle:
  - three strobes at addresses 0, 4, 8 with those values, each 1 cycle after its 4th byte;
  - processor_reset falls in the next cycle.
- Same image, rx_valid toggled every other cycle: identical writes; no byte lost or duplicated.
- Header 0x0000, then header 0x0101 with ADDRESS_WIDTH = 8:
  - error = 1 after each, no strobes, rx_ready stays 1;
  - a following valid header clears error.
- pc model reaches 12 after 7 RUN cycles with N = 3:
  - cycle_count freezes at 7;
  - processor_reset stays 0 for 4 cycles, then done = 1, timeout = 0.
- MAX_CYCLES = 10, pc never reaches 4N: timeout = 1, cycle_count = 10, done after 4 drain cycles.
  - A variant with halt and timeout in the same cycle gives timeout = 0.
- Reset asserted after 2 bytes of word 1: index returns to 0 and HEADER is re-entered.
  - load_request pulsed in RUN is ignored; pulsed in DONE it clears done and cycle_count and raises rx_ready.
